// File: rtl/controlador_entrada_saida.sv
// I/O controller: debounced enter-key input capture and sequential signed binary-to-BCD display path.
// Optional macro ENTRADA_COM_SINAL_EN: sign-extend the switch word instead of zero-extending it.
module controlador_entrada_saida #(
    parameter int LARGURA_SWITCH  = 9,
    parameter int LARGURA_DADO    = 32,
    parameter int NUM_DIGITOS     = 3,
    parameter int DEBOUNCE_CICLOS = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [LARGURA_SWITCH-1:0]   entradaSwitch,
    input  logic                        enter,
    input  logic                        pedidoEntrada,
    output logic                        aguardando,
    output logic                        entradaValida,
    output logic [LARGURA_DADO-1:0]     dadoEntrada,
    input  logic                        pedidoSaida,
    input  logic [LARGURA_DADO-1:0]     dadoSaida,
    output logic                        saidaOcupada,
    output logic [4*NUM_DIGITOS-1:0]    digitos,
    output logic                        negativo,
    output logic                        estouro
);

    localparam int LC  = (DEBOUNCE_CICLOS > 2) ? $clog2(DEBOUNCE_CICLOS) : 1;
    localparam int LI  = $clog2(LARGURA_DADO + 1);
    localparam int LB  = 4 * NUM_DIGITOS;
    localparam int MSB = LARGURA_DADO - 1;

    function automatic logic [LARGURA_DADO-1:0] potencia10(input int n);
        logic [LARGURA_DADO-1:0] p;
        p = {{(LARGURA_DADO-1){1'b0}}, 1'b1};
        for (int i = 0; i < n; i++) begin
            p = p * LARGURA_DADO'(10);
        end
        return p;
    endfunction

    function automatic logic [LB-1:0] ajusta_bcd(input logic [LB-1:0] b);
        logic [LB-1:0] r;
        r = b;
        for (int i = 0; i < NUM_DIGITOS; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = b[4*i +: 4];
            end
        end
        return r;
    endfunction

    localparam logic [LARGURA_DADO-1:0] LIMITE = potencia10(NUM_DIGITOS);

    typedef enum logic {OCIOSO = 1'b0, ESPERA = 1'b1} estado_t;

    logic                      r_enter_s1, r_enter_s2;
    logic [LARGURA_SWITCH-1:0] r_sw_s1, r_sw_s2;
    logic                      r_tecla;
    logic [LC-1:0]             r_cnt_deb;
    estado_t                   r_estado, w_prox_estado;
    logic                      w_captura;
    logic                      r_aguardando, r_valida;
    logic [LARGURA_DADO-1:0]   r_dado_entrada, w_sw_estendido;
    logic                      w_sinc_pressionada, w_evento_press;

    logic                      r_ocupado, r_pend_valido;
    logic [LARGURA_DADO-1:0]   r_pend_dado, r_mag, w_dado_ini, w_mag_ini;
    logic [LI-1:0]             r_cnt_iter;
    logic [LB-1:0]             r_bcd, w_bcd_ajustado, r_digitos;
    logic                      r_neg_conv, r_est_conv, r_negativo, r_estouro;
    logic                      w_fim, w_inicia;

    // Two-flop synchronizers; enter resets to its released (high) level
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_enter_s1 <= 1'b1;
            r_enter_s2 <= 1'b1;
            r_sw_s1    <= '0;
            r_sw_s2    <= '0;
        end else begin
            r_enter_s1 <= enter;
            r_enter_s2 <= r_enter_s1;
            r_sw_s1    <= entradaSwitch;
            r_sw_s2    <= r_sw_s1;
        end
    end

    assign w_sinc_pressionada = ~r_enter_s2;
    assign w_evento_press     = w_sinc_pressionada & ~r_tecla &
                                (r_cnt_deb == LC'(DEBOUNCE_CICLOS - 1));

    // Debouncer: accept a level only after it differs for DEBOUNCE_CICLOS straight cycles
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tecla   <= 1'b0;
            r_cnt_deb <= '0;
        end else if (w_sinc_pressionada != r_tecla) begin
            if (r_cnt_deb == LC'(DEBOUNCE_CICLOS - 1)) begin
                r_tecla   <= w_sinc_pressionada;
                r_cnt_deb <= '0;
            end else begin
                r_cnt_deb <= r_cnt_deb + LC'(1);
            end
        end else begin
            r_cnt_deb <= '0;
        end
    end

`ifdef ENTRADA_COM_SINAL_EN
    assign w_sw_estendido = {{(LARGURA_DADO-LARGURA_SWITCH){r_sw_s2[LARGURA_SWITCH-1]}}, r_sw_s2};
`else
    assign w_sw_estendido = {{(LARGURA_DADO-LARGURA_SWITCH){1'b0}}, r_sw_s2};
`endif

    // Input FSM next state
    always_comb begin
        w_prox_estado = r_estado;
        w_captura     = 1'b0;
        case (r_estado)
            OCIOSO: begin
                if (pedidoEntrada) begin
                    w_prox_estado = ESPERA;
                end else begin
                    w_prox_estado = OCIOSO;
                end
            end
            ESPERA: begin
                if (w_evento_press) begin
                    w_captura     = 1'b1;
                    w_prox_estado = OCIOSO;
                end else if (!pedidoEntrada) begin
                    w_prox_estado = OCIOSO;
                end else begin
                    w_prox_estado = ESPERA;
                end
            end
            default: w_prox_estado = OCIOSO;
        endcase
    end

    // Input FSM state and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado       <= OCIOSO;
            r_aguardando   <= 1'b0;
            r_valida       <= 1'b0;
            r_dado_entrada <= '0;
        end else begin
            r_estado     <= w_prox_estado;
            r_aguardando <= (w_prox_estado == ESPERA);
            r_valida     <= w_captura;
            if (w_captura) begin
                r_dado_entrada <= w_sw_estendido;
            end
        end
    end

    assign w_fim          = r_ocupado && (r_cnt_iter == LI'(LARGURA_DADO));
    assign w_bcd_ajustado = ajusta_bcd(r_bcd);

    // A fresh request beats the slot on the completion edge, matching last-wins
    always_comb begin
        w_inicia   = 1'b0;
        w_dado_ini = dadoSaida;
        if (pedidoSaida && (!r_ocupado || w_fim)) begin
            w_inicia   = 1'b1;
            w_dado_ini = dadoSaida;
        end else if (w_fim && r_pend_valido) begin
            w_inicia   = 1'b1;
            w_dado_ini = r_pend_dado;
        end else begin
            w_inicia   = 1'b0;
            w_dado_ini = dadoSaida;
        end
        w_mag_ini = w_dado_ini[MSB] ? (~w_dado_ini + LARGURA_DADO'(1)) : w_dado_ini;
    end

    // Double-dabble converter; results published only on the completion edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ocupado  <= 1'b0;
            r_cnt_iter <= '0;
            r_mag      <= '0;
            r_bcd      <= '0;
            r_neg_conv <= 1'b0;
            r_est_conv <= 1'b0;
            r_digitos  <= '0;
            r_negativo <= 1'b0;
            r_estouro  <= 1'b0;
        end else begin
            if (w_inicia) begin
                r_ocupado  <= 1'b1;
                r_cnt_iter <= '0;
                r_mag      <= w_mag_ini;
                r_bcd      <= '0;
                r_neg_conv <= w_dado_ini[MSB];
                r_est_conv <= (w_mag_ini >= LIMITE);
            end else if (w_fim) begin
                r_ocupado <= 1'b0;
            end else if (r_ocupado) begin
                r_bcd      <= {w_bcd_ajustado[LB-2:0], r_mag[MSB]};
                r_mag      <= r_mag << 1;
                r_cnt_iter <= r_cnt_iter + LI'(1);
            end
            if (w_fim) begin
                r_digitos  <= r_bcd;
                r_negativo <= r_neg_conv;
                r_estouro  <= r_est_conv;
            end
        end
    end

    // One-deep pending slot, overwritten by later requests during the same conversion
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pend_valido <= 1'b0;
            r_pend_dado   <= '0;
        end else if (pedidoSaida && r_ocupado && !w_fim) begin
            r_pend_valido <= 1'b1;
            r_pend_dado   <= dadoSaida;
        end else if (w_fim) begin
            r_pend_valido <= 1'b0;
        end
    end

    assign aguardando    = r_aguardando;
    assign entradaValida = r_valida;
    assign dadoEntrada   = r_dado_entrada;
    assign saidaOcupada  = r_ocupado;
    assign digitos       = r_digitos;
    assign negativo      = r_negativo;
    assign estouro       = r_estouro;

endmodule

// File: tb/tb_controlador_entrada_saida.sv
// Scoreboard bench for controlador_entrada_saida: key debounce/capture and BCD display path.
module tb_controlador_entrada_saida;

    localparam int W = 32;
    localparam int D = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [8:0]  entradaSwitch = 9'd0;
    logic        enter = 1'b1;
    logic        pedidoEntrada = 1'b0;
    logic        aguardando, entradaValida;
    logic [31:0] dadoEntrada;
    logic        pedidoSaida = 1'b0;
    logic [31:0] dadoSaida = 32'd0;
    logic        saidaOcupada;
    logic [11:0] digitos;
    logic        negativo, estouro;

    int n_vec = 0;
    int n_err = 0;
    int pulsos = 0;
    int ciclos_ocupado = 0;
    int run = 0;
    bit chk = 1'b0;
    logic [31:0] q_ent[$];
    logic [13:0] q_sai[$];

    controlador_entrada_saida #(
        .LARGURA_SWITCH(9), .LARGURA_DADO(W), .NUM_DIGITOS(3), .DEBOUNCE_CICLOS(D)
    ) dut (
        .clock(clock), .reset(reset), .entradaSwitch(entradaSwitch), .enter(enter),
        .pedidoEntrada(pedidoEntrada), .aguardando(aguardando), .entradaValida(entradaValida),
        .dadoEntrada(dadoEntrada), .pedidoSaida(pedidoSaida), .dadoSaida(dadoSaida),
        .saidaOcupada(saidaOcupada), .digitos(digitos), .negativo(negativo), .estouro(estouro)
    );

    always #5 clock = ~clock;

    function automatic logic [13:0] esperado_saida(input logic [31:0] v);
        longint m, r;
        logic [11:0] d;
        m = longint'($signed(v));
        if (m < 0) m = -m;
        r = m % 1000;
        d = {4'(r / 100), 4'((r / 10) % 10), 4'(r % 10)};
        return {v[31], (m >= 1000) ? 1'b1 : 1'b0, d};
    endfunction

    function automatic logic [31:0] estende(input logic [8:0] s);
`ifdef ENTRADA_COM_SINAL_EN
        return {{23{s[8]}}, s};
`else
        return {23'd0, s};
`endif
    endfunction

    // Monitor: pops scoreboards on capture pulses and after every 33-cycle busy run
    always @(negedge clock) begin
        logic [31:0] e_ent;
        logic [13:0] e_sai;
        if (!reset) begin
            run = 0;
            chk = 1'b0;
        end else begin
            if (entradaValida) begin
                pulsos++;
                n_vec++;
                if (q_ent.size() == 0) begin
                    n_err++;
                    $display("FAIL entrada_pulso_inesperado dado=%h", dadoEntrada);
                end else begin
                    e_ent = q_ent.pop_front();
                    if (dadoEntrada !== e_ent) begin
                        n_err++;
                        $display("FAIL entrada_dado obtido=%h esperado=%h", dadoEntrada, e_ent);
                    end
                end
            end
            if (chk) begin
                chk = 1'b0;
                n_vec++;
                if (q_sai.size() == 0) begin
                    n_err++;
                    $display("FAIL saida_atualizacao_inesperada dig=%h", digitos);
                end else begin
                    e_sai = q_sai.pop_front();
                    if ({negativo, estouro, digitos} !== e_sai) begin
                        n_err++;
                        $display("FAIL saida_resultado obtido neg=%b est=%b dig=%h esperado neg=%b est=%b dig=%h",
                                 negativo, estouro, digitos, e_sai[13], e_sai[12], e_sai[11:0]);
                    end
                end
            end
            if (saidaOcupada) begin
                ciclos_ocupado++;
                run++;
                if (run == W + 1) begin
                    chk = 1'b1;
                    run = 0;
                end
            end else if (run != 0) begin
                n_vec++;
                n_err++;
                $display("FAIL saida_duracao obtido=%0d esperado=%0d", run, W + 1);
                run = 0;
            end
        end
    end

    task automatic espera(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic espera_valida(input string nome);
        int t = 0;
        while (!entradaValida && t < 100) begin
            @(negedge clock);
            t++;
        end
        n_vec++;
        if (!entradaValida) begin
            n_err++;
            $display("FAIL %s_timeout obtido=0 esperado=1", nome);
        end
    endtask

    task automatic espera_livre();
        int t = 0;
        do begin
            @(negedge clock);
            t++;
        end while (saidaOcupada && t < 300);
    endtask

    task automatic test_reset();
        espera(3);
        n_vec++;
        if ({aguardando, entradaValida, saidaOcupada, negativo, estouro} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags obtido=%b esperado=00000",
                     {aguardando, entradaValida, saidaOcupada, negativo, estouro});
        end
        n_vec++;
        if (dadoEntrada !== 32'd0) begin
            n_err++;
            $display("FAIL reset_dadoEntrada obtido=%h esperado=0", dadoEntrada);
        end
        n_vec++;
        if (digitos !== 12'd0) begin
            n_err++;
            $display("FAIL reset_digitos obtido=%h esperado=0", digitos);
        end
        reset = 1'b1;
        espera(3);
    endtask

    task automatic test_entrada_bounce();
        int p0 = pulsos;
        entradaSwitch = 9'h1F6;
        pedidoEntrada = 1'b1;
`ifdef ENTRADA_COM_SINAL_EN
        q_ent.push_back(32'hFFFF_FFF6);
`else
        q_ent.push_back(32'h0000_01F6);
`endif
        repeat (5) begin
            enter = 1'b0; espera(5);
            enter = 1'b1; espera(4);
        end
        n_vec++;
        if (aguardando !== 1'b1 || pulsos != p0) begin
            n_err++;
            $display("FAIL bounce_sem_pulso obtido ag=%b pulsos=%0d esperado ag=1 pulsos=%0d",
                     aguardando, pulsos, p0);
        end
        enter = 1'b0;
        espera_valida("bounce");
        n_vec++;
        if (aguardando !== 1'b0) begin
            n_err++;
            $display("FAIL bounce_aguardando obtido=%b esperado=0", aguardando);
        end
        pedidoEntrada = 1'b0;
        espera(3);
        n_vec++;
        if (pulsos - p0 != 1 || q_ent.size() != 0) begin
            n_err++;
            $display("FAIL bounce_pulsos obtido=%0d esperado=1", pulsos - p0);
        end
        enter = 1'b1;
        espera(D + 6);
    endtask

    task automatic test_latencia();
        int n = 0;
        entradaSwitch = 9'h0A5;
        pedidoEntrada = 1'b1;
        n_vec++;
        if (aguardando !== 1'b0) begin
            n_err++;
            $display("FAIL latencia_aguardando_cedo obtido=%b esperado=0", aguardando);
        end
        @(negedge clock);
        n_vec++;
        if (aguardando !== 1'b1) begin
            n_err++;
            $display("FAIL latencia_aguardando_sobe obtido=%b esperado=1", aguardando);
        end
        q_ent.push_back(estende(9'h0A5));
        enter = 1'b0;
        do begin
            @(negedge clock);
            n++;
        end while (!entradaValida && n < 60);
        n_vec++;
        if (n != D + 2) begin
            n_err++;
            $display("FAIL latencia_tecla obtido=%0d esperado=%0d", n, D + 2);
        end
        pedidoEntrada = 1'b0;
        enter = 1'b1;
        espera(D + 6);
    endtask

    task automatic test_tecla_presa();
        int p0;
        enter = 1'b0;
        espera(D + 6);
        p0 = pulsos;
        pedidoEntrada = 1'b1;
        espera(30);
        n_vec++;
        if (pulsos != p0 || aguardando !== 1'b1) begin
            n_err++;
            $display("FAIL tecla_presa obtido pulsos=%0d ag=%b esperado pulsos=%0d ag=1",
                     pulsos, aguardando, p0);
        end
        enter = 1'b1;
        espera(D + 6);
        entradaSwitch = 9'h155;
        q_ent.push_back(estende(9'h155));
        enter = 1'b0;
        espera_valida("tecla_presa");
        pedidoEntrada = 1'b0;
        enter = 1'b1;
        espera(D + 6);
        n_vec++;
        if (q_ent.size() != 0) begin
            n_err++;
            $display("FAIL tecla_presa_fila obtido=%0d esperado=0", q_ent.size());
        end
    endtask

    task automatic test_saida_negativo();
        int b0 = ciclos_ocupado;
        dadoSaida = -32'sd123;
        pedidoSaida = 1'b1;
        q_sai.push_back(esperado_saida(-32'sd123));
        @(negedge clock);
        pedidoSaida = 1'b0;
        espera_livre();
        espera(2);
        n_vec++;
        if (ciclos_ocupado - b0 != W + 1) begin
            n_err++;
            $display("FAIL negativo_ocupado obtido=%0d esperado=%0d", ciclos_ocupado - b0, W + 1);
        end
        n_vec++;
        if ({negativo, estouro, digitos} !== {1'b1, 1'b0, 12'h123}) begin
            n_err++;
            $display("FAIL negativo_display obtido=%b%b%h esperado=10123", negativo, estouro, digitos);
        end
    endtask

    task automatic test_pendente();
        int b0 = ciclos_ocupado;
        dadoSaida = 32'd42;
        pedidoSaida = 1'b1;
        q_sai.push_back(esperado_saida(32'd42));
        q_sai.push_back(esperado_saida(32'd7));
        @(negedge clock);
        pedidoSaida = 1'b0;
        espera(4);
        dadoSaida = 32'd5;
        pedidoSaida = 1'b1;
        @(negedge clock);
        dadoSaida = 32'd7;
        @(negedge clock);
        pedidoSaida = 1'b0;
        espera_livre();
        espera(2);
        n_vec++;
        if (ciclos_ocupado - b0 != 2 * (W + 1) || q_sai.size() != 0) begin
            n_err++;
            $display("FAIL pendente_ocupado obtido=%0d fila=%0d esperado=%0d fila=0",
                     ciclos_ocupado - b0, q_sai.size(), 2 * (W + 1));
        end
    endtask

    task automatic test_estouro();
        logic [31:0] vals[4] = '{32'd1000, 32'h8000_0000, 32'd999, 32'd0};
        for (int i = 0; i < 4; i++) begin
            dadoSaida = vals[i];
            pedidoSaida = 1'b1;
            q_sai.push_back(esperado_saida(vals[i]));
            @(negedge clock);
            pedidoSaida = 1'b0;
            espera_livre();
            espera(2);
            if (i == 1) begin
                n_vec++;
                if ({negativo, estouro, digitos} !== {1'b1, 1'b1, 12'h648}) begin
                    n_err++;
                    $display("FAIL estouro_min obtido=%b%b%h esperado=11648", negativo, estouro, digitos);
                end
            end
        end
        n_vec++;
        if (q_sai.size() != 0) begin
            n_err++;
            $display("FAIL estouro_fila obtido=%0d esperado=0", q_sai.size());
        end
    endtask

    task automatic test_back_to_back();
        int b0 = ciclos_ocupado;
        dadoSaida = 32'd250;
        pedidoSaida = 1'b1;
        q_sai.push_back(esperado_saida(32'd250));
        q_sai.push_back(esperado_saida(-32'sd7));
        @(negedge clock);
        pedidoSaida = 1'b0;
        espera(W);
        dadoSaida = -32'sd7;
        pedidoSaida = 1'b1;
        @(negedge clock);
        pedidoSaida = 1'b0;
        espera_livre();
        espera(2);
        n_vec++;
        if (ciclos_ocupado - b0 != 2 * (W + 1) || q_sai.size() != 0) begin
            n_err++;
            $display("FAIL back_to_back obtido=%0d fila=%0d esperado=%0d fila=0",
                     ciclos_ocupado - b0, q_sai.size(), 2 * (W + 1));
        end
    endtask

    task automatic test_reset_meio();
        int p0;
        dadoSaida = 32'd555;
        pedidoSaida = 1'b1;
        entradaSwitch = 9'h033;
        pedidoEntrada = 1'b1;
        @(negedge clock);
        pedidoSaida = 1'b0;
        espera(10);
        n_vec++;
        if (aguardando !== 1'b1 || saidaOcupada !== 1'b1) begin
            n_err++;
            $display("FAIL reset_meio_pre obtido ag=%b oc=%b esperado ag=1 oc=1", aguardando, saidaOcupada);
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if ({aguardando, entradaValida, saidaOcupada, negativo, estouro, digitos, dadoEntrada} !== 49'd0) begin
            n_err++;
            $display("FAIL reset_meio_saidas obtido ag=%b v=%b oc=%b neg=%b est=%b dig=%h dado=%h esperado=0",
                     aguardando, entradaValida, saidaOcupada, negativo, estouro, digitos, dadoEntrada);
        end
        q_sai.delete();
        q_ent.delete();
        pedidoEntrada = 1'b0;
        espera(3);
        reset = 1'b1;
        p0 = pulsos;
        espera(60);
        n_vec++;
        if ({saidaOcupada, negativo, estouro, digitos} !== 15'd0 || pulsos != p0) begin
            n_err++;
            $display("FAIL reset_meio_pos obtido oc=%b neg=%b est=%b dig=%h pulsos=%0d esperado=0",
                     saidaOcupada, negativo, estouro, digitos, pulsos - p0);
        end
    endtask

    initial begin
        test_reset();
        test_entrada_bounce();
        test_latencia();
        test_tecla_presa();
        test_saida_negativo();
        test_pendente();
        test_estouro();
        test_back_to_back();
        test_reset_meio();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
